// File: rtl/ram_arb_if.sv
// Request/response bundle for one ram_arb requestor port.
interface ram_arb_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 12
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram_arb.sv
// ram_arb: single-array synchronous-read RAM shared by two requestors with round-robin
// arbitration, a RD_LATENCY-deep read response pipe per port and an optional zeroing
// sweep after reset.
module ram_arb #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned RD_LATENCY     = 1,   // 1..4
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic     clk,
    input  logic     rst,
    ram_arb_if.slave a,
    ram_arb_if.slave b,
    output logic     busy
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [0:0] {StClear, StRun} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  ptr_q, ptr_d;   // 0: A wins the next contest, 1: B wins
    logic                  gnt_a, gnt_b;
    logic [1:0]            rd_req;         // [0] A read accepted, [1] B read accepted
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [RD_LATENCY-1:0] vld_q [2];
    logic [DATA_WIDTH-1:0] dat_q [2][RD_LATENCY];

    // Next state, clear address and round-robin grant.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ptr_d     = ptr_q;
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        unique case (state_q)
            StClear: begin
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (a.req_valid && b.req_valid) begin
                    gnt_a = ~ptr_q;
                    gnt_b = ptr_q;
                    ptr_d = ~ptr_q;
                end else begin
                    gnt_a = a.req_valid;
                    gnt_b = b.req_valid;
                end
            end
            default: state_d = StRun;
        endcase
        // Nothing is accepted while reset is held.
        if (rst) begin
            gnt_a = 1'b0;
            gnt_b = 1'b0;
        end
    end

    // Steer the single array port: clear sweep first, then whichever requestor holds the grant.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = a.req_addr;
        mem_wdata = a.req_wdata;
        if (state_q == StClear && !rst) begin
            mem_we    = 1'b1;
            mem_addr  = clr_cnt_q;
            mem_wdata = '0;
        end else if (gnt_a) begin
            mem_we = a.req_we;
        end else if (gnt_b) begin
            mem_we    = b.req_we;
            mem_addr  = b.req_addr;
            mem_wdata = b.req_wdata;
        end
        rd_req = {gnt_b & ~b.req_we, gnt_a & ~a.req_we};
    end

    // FSM, clear counter and arbitration pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? StClear : StRun;
            clr_cnt_q <= '0;
            ptr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ptr_q     <= ptr_d;
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Read response pipes. Data only moves with a valid entry, so the last stage holds the
    // most recently delivered word while rsp_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                vld_q[p] <= '0;
                for (int i = 0; i < RD_LATENCY; i++) begin
                    dat_q[p][i] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                vld_q[p][0] <= rd_req[p];
                if (rd_req[p]) begin
                    dat_q[p][0] <= mem[mem_addr];
                end
                for (int i = 1; i < RD_LATENCY; i++) begin
                    vld_q[p][i] <= vld_q[p][i-1];
                    if (vld_q[p][i-1]) begin
                        dat_q[p][i] <= dat_q[p][i-1];
                    end
                end
            end
        end
    end

    assign a.req_ready = gnt_a;
    assign b.req_ready = gnt_b;
    assign a.rsp_valid = vld_q[0][RD_LATENCY-1];
    assign b.rsp_valid = vld_q[1][RD_LATENCY-1];
    assign a.rsp_rdata = dat_q[0][RD_LATENCY-1];
    assign b.rsp_rdata = dat_q[1][RD_LATENCY-1];
    assign busy        = (state_q == StClear);
endmodule
